// File: rtl/mem_seq_pkg.sv
// Shared types and encodings for the memory access sequencer.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      DATA,
      WB
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and strobes, load extraction and sign/zero extension.
module mem_lane_align
   import mem_seq_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_val
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store funct3 only distinguishes byte/half/word, so the unsigned bit is ignored here.
   always_comb begin
      wdata = store_data;
      wstrb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         2'b01: begin
            wdata = {2{store_data[15:0]}};
            wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_val = {24'b0, byte_sel};
         F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_val = {16'b0, half_sel};
         F3_W:    load_val = rdata;
         default: load_val = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Fetch / data / commit sequencer sharing one memory port with an RV32I datapath.
// Define MEM_TIMEOUT_EN to abort stalled transfers after TIMEOUT_CYC cycles and raise bus_err.
module mem_access_sequencer
   import mem_seq_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             halt,
   input  logic [31:0]      pc,
   input  logic [31:0]      dm_addr,
   input  logic [31:0]      dm_wdata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [31:0]      load_data,
   output logic             commit,
   output logic             busy,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] instret,
   output logic             bus_err
);

   state_t            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       load_data_q, load_data_d;
   logic [CNT_W-1:0]  instret_q, instret_d;

   logic        is_load, is_store, in_xfer, timeout_hit, err_lock;
   logic [31:0] align_wdata, align_load;
   logic [3:0]  align_wstrb;
   logic        unused_pc_lo;

   assign unused_pc_lo = ^pc[1:0];
   assign is_load      = (instr_q[6:0] == OP_LOAD);
   assign is_store     = (instr_q[6:0] == OP_STORE);
   assign in_xfer      = (state_q == FETCH) || (state_q == DATA);

   mem_lane_align u_align (
      .funct3     (instr_q[14:12]),
      .addr_lo    (dm_addr[1:0]),
      .store_data (dm_wdata),
      .rdata      (mem_rdata),
      .wdata      (align_wdata),
      .wstrb      (align_wstrb),
      .load_val   (align_load)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              bus_err_q, bus_err_d;

   // The count restarts whenever a transfer completes, so each new request starts from zero.
   always_comb begin
      timeout_hit = in_xfer && !mem_ack && (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
      wait_cnt_d  = (in_xfer && !mem_ack && !timeout_hit) ? wait_cnt_q + 1'b1 : '0;
      bus_err_d   = bus_err_q | timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign err_lock = bus_err_q;
   assign bus_err  = bus_err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
   assign timeout_hit        = 1'b0;
   assign err_lock           = 1'b0;
   assign bus_err            = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      load_data_d = load_data_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'b0;
      mem_wdata   = 32'b0;
      mem_wstrb   = 4'b0;
      commit      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!halt && !err_lock) state_d = FETCH;
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = {pc[31:2], 2'b00};
            if (mem_ack) begin
               instr_d = mem_rdata;
               state_d = EXEC;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (is_load || is_store) begin
               state_d = DATA;
            end else begin
               commit  = 1'b1;
               state_d = halt ? IDLE : FETCH;
            end
         end
         DATA: begin
            mem_req  = 1'b1;
            mem_we   = is_store;
            mem_addr = {dm_addr[31:2], 2'b00};
            if (is_store) begin
               mem_wdata = align_wdata;
               mem_wstrb = align_wstrb;
            end
            // Stores retire on the ack itself; loads need one more cycle to present load_data.
            if (mem_ack) begin
               if (is_store) begin
                  commit  = 1'b1;
                  state_d = halt ? IDLE : FETCH;
               end else begin
                  load_data_d = align_load;
                  state_d     = WB;
               end
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         WB: begin
            commit  = 1'b1;
            state_d = halt ? IDLE : FETCH;
         end
         default: state_d = IDLE;
      endcase
      instret_d = commit ? instret_q + CNT_W'(1) : instret_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         instr_q     <= 32'b0;
         load_data_q <= 32'b0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         load_data_q <= load_data_d;
         instret_q   <= instret_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = (state_q == EXEC) || (state_q == DATA) || (state_q == WB);
   assign busy        = (state_q != IDLE);
   assign load_data   = load_data_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: a memory responder and a commit monitor check against queued expectations.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset, halt;
   logic [31:0] pc, dm_addr, dm_wdata;
   logic [31:0] instr, load_data, mem_addr, mem_wdata, mem_rdata;
   logic        instr_valid, commit, busy, mem_req, mem_we, mem_ack, bus_err;
   logic [3:0]  mem_wstrb;
   logic [31:0] instret;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      int          latency;
      bit          chk_load;
      logic [31:0] load_val;
   } cmt_t;

   txn_t txn_q[$];
   cmt_t cmt_q[$];

   int checks   = 0;
   int failures = 0;
   int exp_instret = 0;

   int          f_delay, d_delay;
   logic [31:0] f_word, d_word;

   always #5 clk = ~clk;

   mem_access_sequencer #(
      .CNT_W       (32),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .pc          (pc),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .load_data   (load_data),
      .commit      (commit),
      .busy        (busy),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .instret     (instret),
      .bus_err     (bus_err)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   // Memory responder: acks after the configured wait, checks request stability and contents
   int          wcnt;
   bit          txn_active = 0;
   bit          txn_fetch;
   logic [31:0] snap_addr;
   logic [36:0] snap_ctl;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'b0;
   end

   always @(negedge clk) begin
      if (mem_ack) begin
         mem_ack    = 1'b0;
         mem_rdata  = 32'b0;
         txn_active = 0;
      end
      if (!mem_req) begin
         txn_active = 0;
      end else begin
         if (!txn_active) begin
            txn_active = 1;
            wcnt       = 0;
            txn_fetch  = !instr_valid;
            snap_addr  = mem_addr;
            snap_ctl   = {mem_we, mem_wstrb, mem_wdata};
         end else begin
            wcnt++;
            checkOutput("req_addr_stable", mem_addr, snap_addr);
            checkOutput("req_ctl_stable", {mem_we, mem_wstrb, mem_wdata}, snap_ctl);
         end
         if (wcnt == (txn_fetch ? f_delay : d_delay)) begin
            txn_t e;
            mem_ack   = 1'b1;
            mem_rdata = txn_fetch ? f_word : d_word;
            checkOutput("txn_expected", txn_q.size() != 0, 1);
            if (txn_q.size() != 0) begin
               e = txn_q.pop_front();
               checkOutput("mem_addr", mem_addr, e.addr);
               checkOutput("mem_we_wstrb", {mem_we, mem_wstrb}, {e.we, e.wstrb});
               if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
            end
         end
      end
   end

   // Commit monitor: latency counted in busy cycles, load result checked on the commit cycle
   int cyc = 0;

   always @(negedge clk) begin
      cmt_t e;
      #2;
      if (busy) cyc++;
      else cyc = 0;
      if (commit) begin
         checkOutput("commit_expected", cmt_q.size() != 0, 1);
         if (cmt_q.size() != 0) begin
            e = cmt_q.pop_front();
            checkOutput("commit_latency", cyc, e.latency);
            if (e.chk_load) checkOutput("load_data", load_data, e.load_val);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] pc_v, input logic [31:0] iword,
                                input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic [31:0] rdata_v, input int fd, input int dd,
                                input logic [31:0] exp_faddr, input bit has_data,
                                input logic [31:0] exp_daddr, input bit exp_we,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                                input int lat, input bit chk_load, input logic [31:0] exp_load);
      pc       = pc_v;
      dm_addr  = daddr;
      dm_wdata = dwdata;
      f_word   = iword;
      d_word   = rdata_v;
      f_delay  = fd;
      d_delay  = dd;
      txn_q.push_back('{exp_faddr, 1'b0, 4'b0, 32'b0});
      if (has_data) txn_q.push_back('{exp_daddr, exp_we, exp_wstrb, exp_wdata});
      cmt_q.push_back('{lat, chk_load, exp_load});
      exp_instret++;
      halt = 1'b0;
      tick();
      halt = 1'b1;
      for (int i = 0; i < 100 && busy; i++) tick();
      checkOutput("instr_done", busy, 0);
      checkOutput("instret", instret, exp_instret);
      checkOutput("commit_q_drain", cmt_q.size(), 0);
      checkOutput("txn_q_drain", txn_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      halt     = 1'b1;
      pc       = 32'b0;
      dm_addr  = 32'b0;
      dm_wdata = 32'b0;
      f_word   = 32'b0;
      d_word   = 32'b0;
      f_delay  = 0;
      d_delay  = 0;
      repeat (3) tick();
      checkOutput("rst_req", mem_req, 0);
      checkOutput("rst_we", mem_we, 0);
      checkOutput("rst_commit", commit, 0);
      checkOutput("rst_instr_valid", instr_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_bus_err", bus_err, 0);
      checkOutput("rst_wstrb", mem_wstrb, 0);
      checkOutput("rst_instr", instr, 0);
      checkOutput("rst_load_data", load_data, 0);
      checkOutput("rst_instret", instret, 0);
      reset = 1'b0;
      tick();

      // pc, instr, dm_addr, dm_wdata, rdata, fdly, ddly, faddr, data?, daddr, we, wstrb, wdata, lat, load?, load_val
      applyStimulus(32'h0000_0000, 32'h0050_0093, 32'h0, 32'h0, 32'h0, 0, 0,
                    32'h0000_0000, 0, 32'h0, 0, 4'b0000, 32'h0, 2, 0, 32'h0);
      applyStimulus(32'h0000_0004, 32'h0000_0023, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0,
                    32'h0000_0004, 1, 32'h0000_0100, 1, 4'b1000, 32'hA5A5_A5A5, 3, 0, 32'h0);
      applyStimulus(32'h0000_0008, 32'h0000_1003, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, 0,
                    32'h0000_0008, 1, 32'h0000_0200, 0, 4'b0000, 32'h0, 4, 1, 32'hFFFF_8001);
      applyStimulus(32'h0000_000C, 32'h0000_5003, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, 0,
                    32'h0000_000C, 1, 32'h0000_0200, 0, 4'b0000, 32'h0, 4, 1, 32'h0000_8001);
      applyStimulus(32'h0000_0010, 32'h0050_0093, 32'h0, 32'h0, 32'h0, 3, 0,
                    32'h0000_0010, 0, 32'h0, 0, 4'b0000, 32'h0, 5, 0, 32'h0);
      applyStimulus(32'h0000_0017, 32'h0000_2023, 32'h0000_03FE, 32'h1234_5678, 32'h0, 0, 1,
                    32'h0000_0014, 1, 32'h0000_03FC, 1, 4'b1111, 32'h1234_5678, 4, 0, 32'h0);
      applyStimulus(32'h0000_0018, 32'h0000_0003, 32'h0000_0301, 32'h0, 32'h1122_F033, 0, 0,
                    32'h0000_0018, 1, 32'h0000_0300, 0, 4'b0000, 32'h0, 4, 1, 32'hFFFF_FFF0);
      applyStimulus(32'h0000_001C, 32'h0000_1023, 32'h0000_0502, 32'hDEAD_BEEF, 32'h0, 0, 0,
                    32'h0000_001C, 1, 32'h0000_0500, 1, 4'b1100, 32'hBEEF_BEEF, 3, 0, 32'h0);
      applyStimulus(32'h0000_0020, 32'h0000_2003, 32'h0000_0060, 32'h0, 32'hCAFE_F00D, 0, 2,
                    32'h0000_0020, 1, 32'h0000_0060, 0, 4'b0000, 32'h0, 6, 1, 32'hCAFE_F00D);
      applyStimulus(32'h0000_0024, 32'h0000_4003, 32'h0000_0403, 32'h0, 32'h9A00_0000, 0, 0,
                    32'h0000_0024, 1, 32'h0000_0400, 0, 4'b0000, 32'h0, 4, 1, 32'h0000_009A);

      // Reset while a load's data phase is still waiting for its ack
      pc      = 32'h0000_0028;
      dm_addr = 32'h0000_0070;
      f_word  = 32'h0000_2003;
      f_delay = 0;
      d_delay = 60;
      txn_q.push_back('{32'h0000_0028, 1'b0, 4'b0, 32'b0});
      halt = 1'b0;
      tick();
      halt = 1'b1;
      for (int i = 0; i < 20 && !(instr_valid && mem_req); i++) tick();
      checkOutput("data_phase_reached", instr_valid && mem_req, 1);
      tick();
      checkOutput("instret_before_reset", instret, exp_instret);
      reset = 1'b1;
      tick();
      checkOutput("midrst_req", mem_req, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_commit", commit, 0);
      reset = 1'b0;
      repeat (3) tick();
      checkOutput("midrst_stays_idle", busy, 0);
      checkOutput("midrst_instret", instret, 0);
      checkOutput("midrst_txn_q", txn_q.size(), 0);
      exp_instret = 0;

      // Fetch that is never acknowledged
      pc      = 32'h0000_0040;
      f_delay = 1000;
      halt    = 1'b0;
      tick();
      halt = 1'b1;
      repeat (3) tick();
      checkOutput("stall_req_high", mem_req, 1);
      checkOutput("stall_bus_err_low", bus_err, 0);
`ifdef MEM_TIMEOUT_EN
      tick();
      checkOutput("timeout_bus_err", bus_err, 1);
      checkOutput("timeout_busy", busy, 0);
      checkOutput("timeout_req", mem_req, 0);
      halt = 1'b0;
      repeat (3) tick();
      checkOutput("timeout_locked_idle", busy, 0);
      checkOutput("timeout_bus_err_sticky", bus_err, 1);
      halt = 1'b1;
`else
      repeat (10) tick();
      checkOutput("no_timeout_req", mem_req, 1);
      checkOutput("no_timeout_busy", busy, 1);
      checkOutput("no_timeout_bus_err", bus_err, 0);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checkOutput("final_bus_err", bus_err, 0);
      checkOutput("final_idle", busy, 0);
      checkOutput("final_commit_q", cmt_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
